// File: rtl/bcd2bin_pkg.sv
// Shared types and constants for the serial BCD-to-binary converter.
package bcd2bin_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  localparam logic [3:0] BCD_NIBBLE_MAX = 4'd9;
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;

  // Ceiling log2 for sizing counters from parameters.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction step of reverse double-dabble: after a right
// shift, a digit that received a tens-bit (showing as >= 8) is pulled back
// by 3 so it again holds the correct halved decimal value.
module bcd_digit_adj
  import bcd2bin_pkg::*;
(
  input  logic [3:0] i_d,
  output logic [3:0] o_d
);

  assign o_d = (i_d >= BCD_ADJ_THRESH) ? (i_d - 4'd3) : i_d;

endmodule

// File: rtl/bcd2bin_seq.sv
// Serial BCD-to-binary converter (reverse double-dabble), one bit per clock.
// Optional invalid-digit flag enabled by defining BCD2BIN_CHECK_EN; without
// it err is tied low and no check logic exists.
module bcd2bin_seq
  import bcd2bin_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int W      = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic                busy,
  output logic                done,
  output logic [W-1:0]        bin_out,
  output logic                err
);

  localparam int CW = clog2(W + 1);

  state_t              r_state, w_state_nxt;
  logic [4*DIGITS-1:0] r_bcd;
  logic [W-1:0]        r_bin;
  logic [CW-1:0]       r_cnt;
  logic                r_done;
  logic [W-1:0]        r_bin_out;

  logic                w_accept;
  logic                w_last;
  logic [4*DIGITS-1:0] w_bcd_shr;
  logic [4*DIGITS-1:0] w_bcd_adj;
  logic [W-1:0]        w_bin_shr;

  // Right shift of the {bcd, bin} pair; bcd LSB falls into bin MSB.
  assign w_bcd_shr = r_bcd >> 1;
  assign w_bin_shr = {r_bcd[0], r_bin[W-1:1]};

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
        .i_d (w_bcd_shr[4*g +: 4]),
        .o_d (w_bcd_adj[4*g +: 4])
      );
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic plus accept/finish strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = CONV;
        end
      end
      CONV: begin
        if (r_cnt == CW'(W - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Shift datapath, iteration counter, result and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcd     <= '0;
      r_bin     <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_bin_out <= '0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_bcd <= bcd_in;
        r_bin <= '0;
        r_cnt <= '0;
      end else if (r_state == CONV) begin
        r_bcd <= w_bcd_adj;
        r_bin <= w_bin_shr;
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_last) r_bin_out <= w_bin_shr;
    end
  end

`ifdef BCD2BIN_CHECK_EN
  logic w_bad;
  logic r_err_pend;
  logic r_err;

  // Any nibble above 9 marks the incoming operand as malformed.
  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > BCD_NIBBLE_MAX) w_bad = 1'b1;
    end
  end

  // Capture the flag at accept; publish it together with done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_pend <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) r_err_pend <= w_bad;
      if (w_last)   r_err      <= r_err_pend;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign busy    = (r_state == CONV);
  assign done    = r_done;
  assign bin_out = r_bin_out;

endmodule
